// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_pkg
// Brief    : Shared types and constants for the FIFO burst reader.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_LEN_W  = 9;
    localparam int RD_BUF_DEPTH   = 2;
    localparam int RD_OCC_W       = $clog2(RD_BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader_if
// Brief    : FIFO read port plus valid/ready byte stream of the burst reader.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_burst_reader_if
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              r_en;
    logic [DATA_W-1:0] r_data;
    logic              r_empty;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output r_en, m_data, m_valid,
        input  r_data, r_empty, m_ready
    );

    modport slave (
        input  r_en, m_data, m_valid,
        output r_data, r_empty, m_ready
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_obuf.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_obuf
// Brief    : Two-entry output buffer; head register drives the stream.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_obuf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 i_push,
    input  wire  [DATA_W-1:0]   i_push_data,
    input  wire                 i_pop,
    output logic [RD_OCC_W-1:0] o_count,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_valid
);
    localparam logic [RD_OCC_W-1:0] c_full = RD_OCC_W'(RD_BUF_DEPTH);
    localparam logic [RD_OCC_W-1:0] c_one  = RD_OCC_W'(1);

    logic [DATA_W-1:0]   r_head;
    logic [DATA_W-1:0]   r_tail;
    logic [RD_OCC_W-1:0] r_count;
    logic                w_pop;
    logic                w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && (w_pop || (r_count != c_full));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == '0) r_head <= i_push_data;
                    else               r_tail <= i_push_data;
                    r_count <= r_count + c_one;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - c_one;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new byte lands behind whatever remains.
                    if (r_count == c_one) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_data  = r_head;
    assign o_valid = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader
// Brief    : Drains a programmed byte count from the FIFO onto a stream.
//            Optional FIFO_RD_CHECKSUM_EN adds a modulo-256 checksum port.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  wire                 r_clk,
    input  wire                 rst,
    input  wire                 start,
    input  wire  [LEN_W-1:0]    burst_len,
    output logic                busy,
    output logic                done,
    output logic [LEN_W-1:0]    rd_count,
`ifdef FIFO_RD_CHECKSUM_EN
    output logic [7:0]          checksum,
`endif
    fifo_burst_reader_if.master bus
);
    localparam logic [LEN_W-1:0]    c_cnt_max = '1;
    localparam logic [LEN_W-1:0]    c_len_one = LEN_W'(1);
    localparam logic [RD_OCC_W-1:0] c_occ_one = RD_OCC_W'(1);

    rd_state_t           r_state;
    rd_state_t           w_state_nxt;
    logic [LEN_W-1:0]    r_remaining;
    logic [LEN_W-1:0]    r_rd_count;
    logic                r_inflight;
    logic [RD_OCC_W-1:0] w_stored;
    logic [DATA_W-1:0]   w_buf_data;
    logic                w_buf_valid;
    logic                w_pop;
    logic                w_credit;
    logic                w_rd_en;
    logic                w_start_acc;
    logic [2:0]          w_occ_next;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_pop       = w_buf_valid && bus.m_ready;

    // A read is allowed only if the byte it returns is guaranteed a buffer slot.
    assign w_occ_next = 3'(w_stored) + 3'(r_inflight) - 3'(w_pop);
    assign w_credit   = (w_occ_next < 3'(RD_BUF_DEPTH));
    assign w_rd_en    = (r_state == ST_READ) && !bus.r_empty &&
                        (r_remaining != '0) && w_credit;

    fifo_rd_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .clk         (r_clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (bus.r_data),
        .i_pop       (w_pop),
        .o_count     (w_stored),
        .o_data      (w_buf_data),
        .o_valid     (w_buf_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = (burst_len == '0) ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                if (w_rd_en && (r_remaining == c_len_one)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave as the last byte pops so done lands right after it.
                if (!r_inflight && ((w_stored == '0) || ((w_stored == c_occ_one) && w_pop)))
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_rd_count  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_rd_en;
            if (w_start_acc)  r_remaining <= burst_len;
            else if (w_rd_en) r_remaining <= r_remaining - c_len_one;
            if (w_start_acc)
                r_rd_count <= '0;
            else if (w_pop && (r_rd_count != c_cnt_max))
                r_rd_count <= r_rd_count + c_len_one;
        end
    end

`ifdef FIFO_RD_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge r_clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start_acc) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + 8'(w_buf_data);
        end
    end

    assign checksum = r_checksum;
`endif

    assign bus.r_en    = w_rd_en;
    assign bus.m_data  = w_buf_data;
    assign bus.m_valid = w_buf_valid;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign rd_count    = r_rd_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_reader
// Brief    : Directed bench with a FIFO model and a byte-stream scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 9;
    localparam int BUDGET = 2000;

    logic             tb_w_clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] burst_len;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] rd_count;
`ifdef FIFO_RD_CHECKSUM_EN
    logic [7:0]       checksum;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;
    bit rd_fire  = 1'b0;
    int en_cnt   = 0;
    int vld_cnt  = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] pend_q[$];
    logic [7:0] exp_q[$];

    always #5 tb_w_clk = ~tb_w_clk;

    fifo_burst_reader_if #(.DATA_W(DATA_W)) bus ();

    fifo_burst_reader #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .r_clk     (tb_w_clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .rd_count  (rd_count),
`ifdef FIFO_RD_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .bus       (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO model: one-cycle read latency, empty flag follows the queue.
    initial begin
        bus.r_data  = '0;
        bus.r_empty = 1'b1;
    end
    always @(posedge tb_w_clk) begin
        if (rd_fire && (fifo_q.size() > 0)) bus.r_data <= fifo_q.pop_front();
        bus.r_empty <= (fifo_q.size() == 0);
    end

    // Reference behaviour of the reader, kept as plain counters and a byte queue.
    int         exp_pops = 0;
    int         exp_len  = 0;
    bit         exp_busy = 1'b0;
    bit         exp_done = 1'b0;
    int         issued   = 0;
    int         popped   = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
`ifdef FIFO_RD_CHECKSUM_EN
    logic [7:0] exp_csum = '0;
`endif

    always @(negedge tb_w_clk) begin
        logic [7:0] exp_byte;
        bit         nxt_done;
        bit         nxt_busy;
        if (mon_en) begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("rd_count", rd_count, exp_pops);
            check("r_en_while_empty", bus.r_en && bus.r_empty, 0);
            check("outstanding_le_2", (issued - popped) <= 2, 1);
`ifdef FIFO_RD_CHECKSUM_EN
            check("checksum", checksum, exp_csum);
`endif
            if (prev_stall) begin
                check("stall_valid_held", bus.m_valid, 1);
                check("stall_data_held", bus.m_data, prev_data);
            end
        end
        if (bus.r_en)    en_cnt++;
        if (bus.m_valid) vld_cnt++;
        rd_fire = bus.r_en;
        if (rst) begin
            exp_pops = 0; exp_busy = 1'b0; exp_done = 1'b0;
            issued = 0; popped = 0; prev_stall = 1'b0;
            exp_q.delete();
`ifdef FIFO_RD_CHECKSUM_EN
            exp_csum = '0;
`endif
        end else begin
            nxt_done = 1'b0;
            nxt_busy = exp_busy;
            if (bus.r_en) issued++;
            if (bus.m_valid && bus.m_ready) begin
                popped++;
                exp_pops++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_pop: got data 0x%0h, expected no byte", bus.m_data);
                end else begin
                    exp_byte = exp_q.pop_front();
                    if (mon_en) check("m_data_order", bus.m_data, exp_byte);
`ifdef FIFO_RD_CHECKSUM_EN
                    exp_csum = exp_csum + exp_byte;
`endif
                end
                if (exp_pops == exp_len) nxt_done = 1'b1;
            end
            if (start && !exp_busy) begin
                nxt_busy = 1'b1;
                exp_pops = 0;
                exp_len  = int'(burst_len);
`ifdef FIFO_RD_CHECKSUM_EN
                exp_csum = '0;
`endif
                if (burst_len == '0) nxt_done = 1'b1;
            end
            if (exp_done) nxt_busy = 1'b0;
            exp_done   = nxt_done;
            exp_busy   = nxt_busy;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
    end

    function automatic logic [7:0] pat_byte(input int pat, input int i);
        case (pat)
            0:       return 8'(i);
            1:       return 8'(i * 37 + 5);
            2:       return 8'(8'hC0 + i);
            3:       return 8'(255 - i);
            4:       return 8'(i * 3);
            default: return 8'(8'h50 + i);
        endcase
    endfunction

    // Queue n bytes of a pattern as expected; the first n_now go straight into the FIFO.
    task automatic load(input int pat, input int n, input int n_now);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pat_byte(pat, i));
            if (i < n_now) fifo_q.push_back(pat_byte(pat, i));
            else           pend_q.push_back(pat_byte(pat, i));
        end
        @(posedge tb_w_clk); #1;
    endtask

    // lat is the cycle index (start cycle = 0) at which done is observed.
    task automatic run_burst(input int len, input bit tog, input int refill_at,
                             input int busy_start_at, input int rst_at, output int lat);
        bit aborted;
        aborted       = 1'b0;
        bus.m_ready   = 1'b1;
        start         = 1'b1;
        burst_len     = LEN_W'(len);
        @(posedge tb_w_clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!done && (lat < BUDGET)) begin
            if (tog) bus.m_ready = ~bus.m_ready;
            if (lat == refill_at)
                while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
            if (lat == busy_start_at) begin
                start     = 1'b1;
                burst_len = LEN_W'(3);
            end else begin
                start = 1'b0;
            end
            if (lat == rst_at) rst = 1'b1;
            @(posedge tb_w_clk); #1;
            lat++;
            if (rst) begin
                rst = 1'b0;
                check("post_rst_m_valid", bus.m_valid, 0);
                check("post_rst_busy", busy, 0);
                check("post_rst_rd_count", rd_count, 0);
                fifo_q.delete();
                pend_q.delete();
                aborted = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            check("done_within_budget", done, 1);
            @(posedge tb_w_clk); #1;
        end
        bus.m_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int lat;
        int en0;
        int vld0;
        rst         = 1'b1;
        start       = 1'b0;
        burst_len   = '0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge tb_w_clk);
        #1;
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_r_en", bus.r_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_m_data", bus.m_data, 0);
`ifdef FIFO_RD_CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge tb_w_clk); #1;

        // Full 256-byte burst at one byte per cycle.
        load(0, 256, 256);
        en0 = en_cnt; vld0 = vld_cnt;
        run_burst(256, 1'b0, -1, -1, -1, lat);
        check("b256_latency", lat, 259);
        check("b256_rd_count", rd_count, 256);
        check("b256_r_en_cycles", en_cnt - en0, 256);
        check("b256_valid_cycles", vld_cnt - vld0, 256);
`ifdef FIFO_RD_CHECKSUM_EN
        check("b256_checksum", checksum, 8'h80);
`endif

        // Zero-length burst.
        en0 = en_cnt; vld0 = vld_cnt;
        run_burst(0, 1'b0, -1, -1, -1, lat);
        check("zero_latency", lat, 1);
        check("zero_r_en_cycles", en_cnt - en0, 0);
        check("zero_valid_cycles", vld_cnt - vld0, 0);
        check("zero_rd_count", rd_count, 0);

        // Backpressure toggling every cycle.
        load(1, 16, 16);
        run_burst(16, 1'b1, -1, -1, -1, lat);
        check("toggle_rd_count", rd_count, 16);

        // FIFO runs dry after 5 of 10 bytes, refilled at cycle 20.
        load(2, 10, 5);
        run_burst(10, 1'b0, 20, -1, -1, lat);
        check("empty_latency", lat, 28);
        check("empty_rd_count", rd_count, 10);

        // Start pulse while busy must not alter the burst.
        load(3, 16, 16);
        run_burst(16, 1'b0, -1, 5, -1, lat);
        check("busy_start_latency", lat, 19);
        check("busy_start_rd_count", rd_count, 16);

        // Reset in mid-burst, then a clean burst.
        load(4, 32, 32);
        run_burst(32, 1'b0, -1, -1, 9, lat);
        repeat (2) @(posedge tb_w_clk);
        #1;
        load(5, 8, 8);
        run_burst(8, 1'b0, -1, -1, -1, lat);
        check("after_rst_latency", lat, 11);
        check("after_rst_rd_count", rd_count, 8);

        repeat (3) @(posedge tb_w_clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
